regfile_wr_arbiter: RTL and testbench
=====================================

Name: regfile_wr_arbiter

Overview:
- Shares the single register-file write port between two writeback sources: EX (ALU result) and MEM (load data).
- Each source has a valid/ready handshake into its own one-entry holding register.
- A round-robin arbiter picks one pending write per cycle and drives a registered write strobe: wr_en feeds the 5-to-32 write-enable decoder enable, wr_rd feeds its code, wr_data goes to the register array.
- Writes to X31 (XZR) are discarded.

Parameters:
- DATA_W, 64, width of write data.
- ADDR_W, 5, register index width. Fixed at 5 for the 32-entry file; X31 is index 31.

Ports:
- clk  input  1  system clock, all state updates on posedge.
- reset  input  1  asynchronous, active-high reset.
- ex_valid  input  1  EX write request.
- ex_ready  output  1  EX holding register can accept this cycle.
- ex_rd  input  ADDR_W  EX destination register.
- ex_data  input  DATA_W  EX write data.
- mem_valid  input  1  MEM write request.
- mem_ready  output  1  MEM holding register can accept this cycle.
- mem_rd  input  ADDR_W  MEM destination register.
- mem_data  input  DATA_W  MEM write data.
- wr_en  output  1  registered write strobe to the decoder enable.
- wr_rd  output  ADDR_W  registered write index to the decoder code.
- wr_data  output  DATA_W  registered write data.
- conflict_cnt  output  16  present only with REGWR_CONFLICT_CNT_EN.

Behaviour:

Holding registers:
- State per source: occ (1 bit), rd, data.
- Reset: occ=0, rd=0, data=0.

Handshake:
- x_ready = !x_occ | x_grant.
  - x_grant is a combinational arbiter output in the same cycle.
- Transfer occurs when x_valid & x_ready at posedge.
- On transfer with x_rd != 31: load rd/data and set occ=1. This overrides the clear caused by a grant in the same cycle.
- On transfer with x_rd == 31: request is consumed and nothing is stored. occ stays 0, or is cleared if granted that cycle. No write is ever produced.
- If not transferring and granted: occ clears.

Arbitration (combinational, on occ bits only):
- Only EX occupied: grant EX.
- Only MEM occupied: grant MEM.
- Both occupied: grant the source opposite last_grant.
- last_grant is 1 bit (0=EX, 1=MEM), updated on every grant. Reset value is EX, so the first conflict grants MEM.

Output register:
- At each posedge: wr_en <= any grant; wr_rd/wr_data <= granted holding contents. If no grant, wr_rd/wr_data hold their previous values.
- Reset: wr_en=0, wr_rd=0, wr_data=0.

Latency and throughput:
- A request transferred at edge k is granted earliest in cycle k..k+1.
- wr_en is high during the cycle after edge k+1. Minimum latency is 1 cycle from holding register to strobe.
- Sustained throughput is 1 write per cycle total. Each source gets 1 per cycle when alone, 1 per 2 cycles under continuous conflict.

Same rd pending in both sources:
- No merging. Both writes are issued in round-robin order.
- Ordering between EX and MEM to the same rd is the pipeline's responsibility.

Reset mid-operation:
- Pending holding contents are dropped and wr_en deasserts immediately (asynchronous).
- last_grant returns to EX.

wr_en is never asserted with wr_rd == 31.

Optional Feature:
- Macro: REGWR_CONFLICT_CNT_EN.
- Defined:
  - conflict_cnt port exists.
  - 16-bit counter increments at each posedge where both occ bits are 1.
  - Saturates at 16'hFFFF.
  - Reset value 0 (asynchronous).
- Undefined: the port and counter logic are absent. All other behaviour is identical.

Test Plan:
- Reset then idle:
  - Assert reset mid-cycle → wr_en=0, wr_rd=0, wr_data=0, ex_ready=1, mem_ready=1 immediately.
  - Hold for 5 cycles → wr_en stays 0.
- Single EX write:
  - ex_valid=1, ex_rd=5, ex_data=64'hDEAD_BEEF for 1 cycle → next cycle wr_en=1, wr_rd=5, wr_data=64'hDEAD_BEEF.
  - Following cycle → wr_en=0.
- Simultaneous conflict:
  - After reset, ex (rd=3, data=1) and mem (rd=7, data=2) valid in the same cycle → strobe order is rd=7 then rd=3 on consecutive cycles.
  - ex_ready=0 in the cycle between them.
  - conflict_cnt=1 when REGWR_CONFLICT_CNT_EN is defined.
- XZR drop:
  - mem_valid=1, mem_rd=31, data=64'h55 → mem_ready=1, transfer occurs, wr_en never asserts over the next 4 cycles.
- Back-to-back streaming:
  - Both sources valid continuously for 8 cycles with incrementing rd (EX 0..7, MEM 8..15) → wr_en=1 every cycle after the first.
  - Strobes alternate MEM/EX.
  - Per-source order is preserved.
  - No transfer is lost; 16 total strobes.
- Reset mid-operation:
  - Both sources occupied, reset pulsed for 1 cycle → wr_en drops at once and no stale write follows.
  - Next conflict grants MEM first.

Source files
------------

// File: rtl/regfile_wr_arbiter.sv
// regfile_wr_arbiter: round-robin EX/MEM writeback arbiter for the register-file write port; REGWR_CONFLICT_CNT_EN adds a saturating conflict counter.
module regfile_wr_arbiter #(
  parameter int DATA_W = 64,
  parameter int ADDR_W = 5
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              ex_valid,
  output logic              ex_ready,
  input  logic [ADDR_W-1:0] ex_rd,
  input  logic [DATA_W-1:0] ex_data,
  input  logic              mem_valid,
  output logic              mem_ready,
  input  logic [ADDR_W-1:0] mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_rd,
  output logic [DATA_W-1:0] wr_data
`ifdef REGWR_CONFLICT_CNT_EN
  ,
  output logic [15:0]       conflict_cnt
`endif
);
  localparam logic [ADDR_W-1:0] XZR = '1;
  logic              ex_occ, mem_occ, last_grant, ex_grant, mem_grant, ex_load, mem_load;
  logic [ADDR_W-1:0] ex_rd_q, mem_rd_q;
  logic [DATA_W-1:0] ex_data_q, mem_data_q;
  // last_grant=1 means MEM went last, so EX wins the next conflict
  assign ex_grant  = ex_occ & (!mem_occ | last_grant);
  assign mem_grant = mem_occ & (!ex_occ | !last_grant);
  assign ex_ready  = !ex_occ | ex_grant;
  assign mem_ready = !mem_occ | mem_grant;
  assign ex_load   = ex_valid & ex_ready & (ex_rd != XZR);
  assign mem_load  = mem_valid & mem_ready & (mem_rd != XZR);
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      ex_occ     <= 1'b0;
      ex_rd_q    <= '0;
      ex_data_q  <= '0;
      mem_occ    <= 1'b0;
      mem_rd_q   <= '0;
      mem_data_q <= '0;
      last_grant <= 1'b0;
      wr_en      <= 1'b0;
      wr_rd      <= '0;
      wr_data    <= '0;
    end else begin
      ex_occ  <= ex_load | (ex_occ & !ex_grant);
      mem_occ <= mem_load | (mem_occ & !mem_grant);
      if (ex_load) begin
        ex_rd_q   <= ex_rd;
        ex_data_q <= ex_data;
      end
      if (mem_load) begin
        mem_rd_q   <= mem_rd;
        mem_data_q <= mem_data;
      end
      wr_en <= ex_grant | mem_grant;
      if (ex_grant | mem_grant) begin
        last_grant <= mem_grant;
        wr_rd      <= mem_grant ? mem_rd_q : ex_rd_q;
        wr_data    <= mem_grant ? mem_data_q : ex_data_q;
      end
    end
  end
`ifdef REGWR_CONFLICT_CNT_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) conflict_cnt <= '0;
    else if (ex_occ & mem_occ & ~&conflict_cnt) conflict_cnt <= conflict_cnt + 16'd1;
  end
`endif
endmodule

// File: tb/tb_regfile_wr_arbiter.sv
// tb_regfile_wr_arbiter: directed stimulus with a queue scoreboard checked by a strobe monitor.
module tb_regfile_wr_arbiter;
  logic        clk = 1'b0, reset = 1'b0;
  logic        ex_valid = 1'b0, mem_valid = 1'b0, ex_ready, mem_ready, wr_en;
  logic [4:0]  ex_rd = '0, mem_rd = '0, wr_rd;
  logic [63:0] ex_data = '0, mem_data = '0, wr_data;
`ifdef REGWR_CONFLICT_CNT_EN
  logic [15:0] conflict_cnt;
`endif
  int          total = 0, bad = 0, strobes = 0;
  logic [4:0]  exp_rd[$];
  logic [63:0] exp_data[$];
  regfile_wr_arbiter dut (
    .clk(clk), .reset(reset),
    .ex_valid(ex_valid), .ex_ready(ex_ready), .ex_rd(ex_rd), .ex_data(ex_data),
    .mem_valid(mem_valid), .mem_ready(mem_ready), .mem_rd(mem_rd), .mem_data(mem_data),
    .wr_en(wr_en), .wr_rd(wr_rd), .wr_data(wr_data)
`ifdef REGWR_CONFLICT_CNT_EN
    , .conflict_cnt(conflict_cnt)
`endif
  );
  always #5 clk = ~clk;
  task automatic chk(input string n, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", n, act, exp);
    end
  endtask
  task automatic step();
    @(posedge clk);
    #1;
  endtask
  task automatic expect_wr(input logic [4:0] rd, input logic [63:0] data);
    exp_rd.push_back(rd);
    exp_data.push_back(data);
  endtask
  always @(negedge clk) begin
    if (wr_en) begin
      strobes++;
      chk("strobe_not_xzr", 64'(wr_rd == 5'd31), 64'd0);
      if (exp_rd.size() == 0) begin
        total++;
        bad++;
        $display("FAIL unexpected_strobe: got rd=%0d data=%h want none", wr_rd, wr_data);
      end else begin
        chk("strobe_rd", 64'(wr_rd), 64'(exp_rd.pop_front()));
        chk("strobe_data", wr_data, exp_data.pop_front());
      end
    end
  end
  logic er, mr;
  int   ei, mi, s0;
  initial begin
    #2 reset = 1'b1;
    #1;
    chk("rst_wr_en", 64'(wr_en), 64'd0);
    chk("rst_wr_rd", 64'(wr_rd), 64'd0);
    chk("rst_wr_data", wr_data, 64'd0);
    chk("rst_ex_ready", 64'(ex_ready), 64'd1);
    chk("rst_mem_ready", 64'(mem_ready), 64'd1);
    for (int i = 0; i < 5; i++) begin
      step();
      chk("rst_hold_wr_en", 64'(wr_en), 64'd0);
    end
    reset = 1'b0;
    step();
    ex_valid = 1'b1; ex_rd = 5'd5; ex_data = 64'hDEAD_BEEF;
    expect_wr(5'd5, 64'hDEAD_BEEF);
    step();
    ex_valid = 1'b0;
    step();
    chk("single_wr_en", 64'(wr_en), 64'd1);
    chk("single_wr_rd", 64'(wr_rd), 64'd5);
    chk("single_wr_data", wr_data, 64'hDEAD_BEEF);
    step();
    chk("single_wr_en_off", 64'(wr_en), 64'd0);
    ex_valid = 1'b1; ex_rd = 5'd3; ex_data = 64'd1;
    mem_valid = 1'b1; mem_rd = 5'd7; mem_data = 64'd2;
    expect_wr(5'd7, 64'd2);
    expect_wr(5'd3, 64'd1);
    step();
    ex_valid = 1'b0; mem_valid = 1'b0;
    chk("conflict_ex_ready", 64'(ex_ready), 64'd0);
    chk("conflict_mem_ready", 64'(mem_ready), 64'd1);
    step();
    chk("conflict_first_rd", 64'(wr_rd), 64'd7);
`ifdef REGWR_CONFLICT_CNT_EN
    chk("conflict_cnt", 64'(conflict_cnt), 64'd1);
`endif
    step();
    chk("conflict_second_rd", 64'(wr_rd), 64'd3);
    step();
    mem_valid = 1'b1; mem_rd = 5'd31; mem_data = 64'h55;
    chk("xzr_mem_ready", 64'(mem_ready), 64'd1);
    step();
    mem_valid = 1'b0;
    chk("xzr_ready_after", 64'(mem_ready), 64'd1);
    for (int i = 0; i < 4; i++) begin
      step();
      chk("xzr_no_wr", 64'(wr_en), 64'd0);
    end
    for (int i = 0; i < 8; i++) begin
      expect_wr(5'(i + 8), 64'h200 + 64'(i));
      expect_wr(5'(i), 64'h100 + 64'(i));
    end
    s0 = strobes; ei = 0; mi = 0;
    for (int c = 1; c <= 40 && (ei < 8 || mi < 8); c++) begin
      ex_valid = ei < 8; ex_rd = 5'(ei); ex_data = 64'h100 + 64'(ei);
      mem_valid = mi < 8; mem_rd = 5'(mi + 8); mem_data = 64'h200 + 64'(mi);
      er = ex_valid & ex_ready;
      mr = mem_valid & mem_ready;
      step();
      ei += int'(er);
      mi += int'(mr);
      if (c >= 2) chk("stream_wr_en", 64'(wr_en), 64'd1);
    end
    ex_valid = 1'b0; mem_valid = 1'b0;
    chk("stream_all_sent", 64'(ei + mi), 64'd16);
    for (int i = 0; i < 4; i++) step();
    chk("stream_strobes", 64'(strobes - s0), 64'd16);
    ex_valid = 1'b1; ex_rd = 5'd1; ex_data = 64'h11;
    mem_valid = 1'b1; mem_rd = 5'd2; mem_data = 64'h22;
    expect_wr(5'd2, 64'h22);
    step();
    ex_valid = 1'b0;
    mem_rd = 5'd4; mem_data = 64'h44;
    step();
    mem_valid = 1'b0;
    @(negedge clk);
    #2 reset = 1'b1;
    #1;
    chk("midrst_wr_en", 64'(wr_en), 64'd0);
    chk("midrst_wr_rd", 64'(wr_rd), 64'd0);
    chk("midrst_ex_ready", 64'(ex_ready), 64'd1);
    chk("midrst_mem_ready", 64'(mem_ready), 64'd1);
    @(posedge clk);
    #3 reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      chk("midrst_no_stale", 64'(wr_en), 64'd0);
    end
    ex_valid = 1'b1; ex_rd = 5'd10; ex_data = 64'hA;
    mem_valid = 1'b1; mem_rd = 5'd11; mem_data = 64'hB;
    expect_wr(5'd11, 64'hB);
    expect_wr(5'd10, 64'hA);
    step();
    ex_valid = 1'b0; mem_valid = 1'b0;
    step();
    chk("postrst_first_mem", 64'(wr_rd), 64'd11);
    for (int i = 0; i < 4; i++) step();
    chk("queue_empty", 64'(exp_rd.size()), 64'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
